ioctl_sdram_loader: RTL and testbench
=====================================

IOCTL_SDRAM_LOADER -- requirements
Module: ioctl_sdram_loader

Interface
REQ-001 SHALL have parameter ROM_INDEX, default 16'h0000; the ioctl_index value accepted as ROM download.
REQ-002 SHALL have parameter BYTE_LIMIT, default 27'h0100000; bytes at ioctl_addr >= BYTE_LIMIT are discarded.
REQ-003 SHALL have parameter FILL_BYTE, default 8'hFF; high byte used when flushing an unpaired low byte.
REQ-004 i_EMU_MCLK  in  1  single clock for all logic; one clock only.
REQ-005 i_EMU_INITRST  in  1  synchronous, active-high reset.
REQ-006 i_IOCTL_INDEX  in  16  download target index.
REQ-007 i_IOCTL_DOWNLOAD  in  1  high for the whole download.
REQ-008 i_IOCTL_ADDR  in  27  byte address.
REQ-009 i_IOCTL_DATA  in  8  byte data.
REQ-010 i_IOCTL_WR  in  1  one-cycle byte strobe.
REQ-011 o_IOCTL_WAIT  out  1  back-pressure to the ioctl source.
REQ-012 o_SDRAM_WR_REQ  out  1  write request to the SDRAM controller.
REQ-013 o_SDRAM_ADDR  out  24  word address, equal to byte address >> 1.
REQ-014 o_SDRAM_DATA  out  16  {high byte (odd addr), low byte (even addr)}.
REQ-015 i_SDRAM_WR_ACK  in  1  one-cycle acceptance pulse from the controller.
REQ-016 o_LOADING  out  1  matching download in progress or flush pending.
REQ-017 o_LOAD_DONE  out  1  sticky completion flag.
REQ-018 o_OVERRUN  out  1  sticky flag for a strobe received while a write is pending.

Function
REQ-019 Match = i_IOCTL_DOWNLOAD & (i_IOCTL_INDEX == ROM_INDEX); all strobes without match SHALL be ignored.
REQ-020 FSM states SHALL be IDLE, HAVE_LO, REQ, FLUSH, DONE.
REQ-021 A rising edge of match SHALL, from any state, clear o_LOAD_DONE and o_OVERRUN, set o_LOADING, and enter IDLE.
REQ-022 IDLE/HAVE_LO + accepted strobe at an even address SHALL latch the byte as the low byte and record the word address, then enter HAVE_LO; a second even byte overwrites it.
REQ-023 IDLE/HAVE_LO + accepted strobe at an odd address SHALL form the word; low = latched byte if the word address matches, else FILL_BYTE; then enter REQ.
REQ-024 On entering REQ, o_SDRAM_WR_REQ and o_IOCTL_WAIT SHALL go high on the cycle after the strobe, registered.
REQ-025 o_SDRAM_ADDR and o_SDRAM_DATA SHALL be stable while o_SDRAM_WR_REQ is high.
REQ-026 REQ SHALL hold until i_SDRAM_WR_ACK is sampled high; REQ and WAIT SHALL be low on the next cycle.
REQ-027 After REQ, the FSM SHALL enter DONE if the flush/end condition is set, else IDLE.
REQ-028 An ACK outside REQ SHALL be ignored.
REQ-029 A strobe in REQ/FLUSH SHALL drop the byte and set o_OVERRUN.
REQ-030 A falling edge of match in HAVE_LO SHALL enter FLUSH: form word {FILL_BYTE, low}, then enter REQ with the end condition set.
REQ-031 A falling edge of match in IDLE SHALL enter DONE directly.
REQ-032 A falling edge of match in REQ SHALL complete the write, then enter DONE.
REQ-033 DONE SHALL set o_LOAD_DONE, clear o_LOADING, and remain until a new match rising edge or reset.
REQ-034 A strobe with addr >= BYTE_LIMIT SHALL be discarded with no state change.
REQ-035 Word address SHALL be the low 24 bits of addr[24:1].

Reset
REQ-036 Reset SHALL move the FSM to IDLE and clear all outputs, latched bytes, and flags to 0, including mid-request.
REQ-037 An ACK arriving in the cycle after reset SHALL be ignored.
REQ-038 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-039 Scenario: addr 0 = 0x34, then addr 1 = 0x12, ACK after 3 cycles -> one request with ADDR 0x000000 and DATA 0x1234; WAIT high for exactly 4 cycles.
REQ-040 Scenario: 3 bytes 0xAA/0xBB/0xCC, then download falls -> writes 0xBBAA@0 and 0xFFCC@1; o_LOAD_DONE = 1 and o_LOADING = 0.
REQ-041 Scenario: strobe during pending REQ -> byte dropped, o_OVERRUN = 1, and the data in flight is unchanged.
REQ-042 Scenario: index 0x0001 download -> no requests and o_LOADING stays 0.
REQ-043 Scenario: reset while REQ is high -> all outputs 0 next cycle; a late ACK is ignored.
REQ-044 Scenario: byte at addr 0x0100000 -> discarded; second download rising edge -> o_LOAD_DONE cleared.

Source files
------------

// File: rtl/ioctl_sdram_loader.sv
// Packs an ioctl byte stream into 16-bit SDRAM word writes with a request/ack
// handshake, back-pressure, an odd-length tail flush and sticky status flags.
module ioctl_sdram_loader #(
  parameter logic [15:0] ROM_INDEX  = 16'h0000,
  parameter logic [26:0] BYTE_LIMIT = 27'h0100000,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_INITRST,
  input  logic [15:0] i_IOCTL_INDEX,
  input  logic        i_IOCTL_DOWNLOAD,
  input  logic [26:0] i_IOCTL_ADDR,
  input  logic [7:0]  i_IOCTL_DATA,
  input  logic        i_IOCTL_WR,
  output logic        o_IOCTL_WAIT,
  output logic        o_SDRAM_WR_REQ,
  output logic [23:0] o_SDRAM_ADDR,
  output logic [15:0] o_SDRAM_DATA,
  input  logic        i_SDRAM_WR_ACK,
  output logic        o_LOADING,
  output logic        o_LOAD_DONE,
  output logic        o_OVERRUN
);

  typedef enum logic [2:0] {IDLE, HAVE_LO, REQ, FLUSH, DONE} state_t;

  state_t      state, state_next;
  logic        match, match_q, match_rise, match_fall, strobe_ok;
  logic [23:0] word_addr;
  logic [7:0]  lo_byte, lo_byte_next;
  logic [23:0] lo_addr, lo_addr_next;
  logic [23:0] addr_q, addr_next;
  logic [15:0] data_q, data_next;
  logic        end_q, end_next;
  logic        loading_q, loading_next;
  logic        done_q, done_next;
  logic        overrun_q, overrun_next;
  logic        wr_req_q;

  assign match      = i_IOCTL_DOWNLOAD && (i_IOCTL_INDEX == ROM_INDEX);
  assign match_rise = match && !match_q;
  assign match_fall = !match && match_q;
  assign strobe_ok  = match && i_IOCTL_WR && (i_IOCTL_ADDR < BYTE_LIMIT);
  assign word_addr  = i_IOCTL_ADDR[24:1];

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_next   = state;
    lo_byte_next = lo_byte;
    lo_addr_next = lo_addr;
    addr_next    = addr_q;
    data_next    = data_q;
    end_next     = end_q;
    loading_next = loading_q;
    done_next    = done_q;
    overrun_next = overrun_q;

    if (match_rise) begin
      // A new download restarts the loader from whatever state it was in.
      state_next   = IDLE;
      end_next     = 1'b0;
      loading_next = 1'b1;
      done_next    = 1'b0;
      overrun_next = 1'b0;
    end else begin
      case (state)
        IDLE, HAVE_LO: begin
          if (match_fall) begin
            state_next = (state == HAVE_LO) ? FLUSH : DONE;
          end else if (strobe_ok) begin
            if (!i_IOCTL_ADDR[0]) begin
              lo_byte_next = i_IOCTL_DATA;
              lo_addr_next = word_addr;
              state_next   = HAVE_LO;
            end else begin
              // An odd byte only pairs with a low byte latched for the same word.
              addr_next  = word_addr;
              data_next  = {i_IOCTL_DATA,
                            ((state == HAVE_LO) && (lo_addr == word_addr)) ? lo_byte : FILL_BYTE};
              end_next   = 1'b0;
              state_next = REQ;
            end
          end
        end
        FLUSH: begin
          if (strobe_ok) overrun_next = 1'b1;
          addr_next  = lo_addr;
          data_next  = {FILL_BYTE, lo_byte};
          end_next   = 1'b1;
          state_next = REQ;
        end
        REQ: begin
          if (strobe_ok)  overrun_next = 1'b1;
          if (match_fall) end_next     = 1'b1;
          if (i_SDRAM_WR_ACK) state_next = (end_q || match_fall) ? DONE : IDLE;
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end

    if (state_next == DONE) begin
      done_next    = 1'b1;
      loading_next = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      state     <= IDLE;
      match_q   <= 1'b0;
      lo_byte   <= '0;
      lo_addr   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      end_q     <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      wr_req_q  <= 1'b0;
    end else begin
      state     <= state_next;
      match_q   <= match;
      lo_byte   <= lo_byte_next;
      lo_addr   <= lo_addr_next;
      addr_q    <= addr_next;
      data_q    <= data_next;
      end_q     <= end_next;
      loading_q <= loading_next;
      done_q    <= done_next;
      overrun_q <= overrun_next;
      wr_req_q  <= (state_next == REQ);
    end
  end

  assign o_SDRAM_WR_REQ = wr_req_q;
  assign o_IOCTL_WAIT   = wr_req_q;
  assign o_SDRAM_ADDR   = addr_q;
  assign o_SDRAM_DATA   = data_q;
  assign o_LOADING      = loading_q;
  assign o_LOAD_DONE    = done_q;
  assign o_OVERRUN      = overrun_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_ioctl_sdram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] index;
  logic        dl;
  logic [26:0] addr;
  logic [7:0]  data;
  logic        wr;
  logic        wait_o;
  logic        wr_req;
  logic [23:0] sd_addr;
  logic [15:0] sd_data;
  logic        ack;
  logic        loading;
  logic        done;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] wa[$];
  logic [15:0] wd[$];

  ioctl_sdram_loader dut (
    .i_EMU_MCLK      (clk),
    .i_EMU_INITRST   (rst),
    .i_IOCTL_INDEX   (index),
    .i_IOCTL_DOWNLOAD(dl),
    .i_IOCTL_ADDR    (addr),
    .i_IOCTL_DATA    (data),
    .i_IOCTL_WR      (wr),
    .o_IOCTL_WAIT    (wait_o),
    .o_SDRAM_WR_REQ  (wr_req),
    .o_SDRAM_ADDR    (sd_addr),
    .o_SDRAM_DATA    (sd_data),
    .i_SDRAM_WR_ACK  (ack),
    .o_LOADING       (loading),
    .o_LOAD_DONE     (done),
    .o_OVERRUN       (overrun)
  );

  always #5 clk = ~clk;

  // Accepted writes: the request is high while ack is presented.
  always @(negedge clk) begin
    if (wr_req && ack) begin
      wa.push_back(sd_addr);
      wd.push_back(sd_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [26:0] a, input logic [7:0] d);
    addr = a;
    data = d;
    wr   = 1'b1;
    step();
    wr   = 1'b0;
  endtask

  task automatic ack_after(input int n, output int cnt);
    cnt = wait_o ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (wait_o) cnt++;
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if ({wr_req, wait_o, loading, done, overrun, sd_addr, sd_data} !== '0) begin
      $display("FAIL reset_state: got %b/%b/%b/%b/%b %h %h want all zero",
               wr_req, wait_o, loading, done, overrun, sd_addr, sd_data);
      n_err++;
    end
  endtask

  task automatic test_basic();
    int cnt;
    int base;
    base = wa.size();
    dl = 1'b1;
    step();
    send(27'd0, 8'h34);
    send(27'd1, 8'h12);
    n_cmp++;
    if (wr_req !== 1'b1) begin
      $display("FAIL basic_req_rise: got %b want 1", wr_req); n_err++;
    end
    ack_after(3, cnt);
    n_cmp++;
    if (cnt !== 4) begin
      $display("FAIL basic_wait_cycles: got %0d want 4", cnt); n_err++;
    end
    n_cmp++;
    if ({wr_req, wait_o} !== 2'b00) begin
      $display("FAIL basic_req_drop: got %b want 00", {wr_req, wait_o}); n_err++;
    end
    n_cmp++;
    if (wa.size() !== base + 1) begin
      $display("FAIL basic_count: got %0d want %0d", wa.size(), base + 1); n_err++;
    end else if ({wa[base], wd[base]} !== {24'h000000, 16'h1234}) begin
      $display("FAIL basic_word: got %h/%h want 000000/1234", wa[base], wd[base]); n_err++;
    end
    dl = 1'b0;
    step();
    n_cmp++;
    if ({done, loading} !== 2'b10) begin
      $display("FAIL basic_done: got done=%b loading=%b want 1/0", done, loading); n_err++;
    end
  endtask

  task automatic test_flush();
    int cnt;
    int base;
    base = wa.size();
    dl = 1'b1;
    step();
    n_cmp++;
    if ({done, loading} !== 2'b01) begin
      $display("FAIL flush_restart: got done=%b loading=%b want 0/1", done, loading); n_err++;
    end
    send(27'd0, 8'hAA);
    send(27'd1, 8'hBB);
    ack_after(1, cnt);
    send(27'd2, 8'hCC);
    dl = 1'b0;
    step();
    step();
    n_cmp++;
    if ({wr_req, sd_addr, sd_data} !== {1'b1, 24'h000001, 16'hFFCC}) begin
      $display("FAIL flush_req: got %b %h %h want 1 000001 ffcc", wr_req, sd_addr, sd_data); n_err++;
    end
    ack_after(1, cnt);
    n_cmp++;
    if (wa.size() !== base + 2) begin
      $display("FAIL flush_count: got %0d want %0d", wa.size(), base + 2); n_err++;
    end else if ({wa[base], wd[base], wa[base+1], wd[base+1]} !==
                 {24'h000000, 16'hBBAA, 24'h000001, 16'hFFCC}) begin
      $display("FAIL flush_words: got %h/%h %h/%h want 000000/bbaa 000001/ffcc",
               wa[base], wd[base], wa[base+1], wd[base+1]); n_err++;
    end
    n_cmp++;
    if ({done, loading} !== 2'b10) begin
      $display("FAIL flush_done: got done=%b loading=%b want 1/0", done, loading); n_err++;
    end
  endtask

  task automatic test_overrun();
    int cnt;
    dl = 1'b1;
    step();
    send(27'd0, 8'h11);
    send(27'd1, 8'h22);
    send(27'd2, 8'h99);
    n_cmp++;
    if ({overrun, wr_req, sd_addr, sd_data} !== {2'b11, 24'h000000, 16'h2211}) begin
      $display("FAIL overrun_hold: got ovr=%b req=%b %h %h want 1 1 000000 2211",
               overrun, wr_req, sd_addr, sd_data); n_err++;
    end
    ack_after(0, cnt);
    send(27'd3, 8'h44);
    n_cmp++;
    if ({wr_req, sd_addr, sd_data} !== {1'b1, 24'h000001, 16'h44FF}) begin
      $display("FAIL overrun_dropped_byte: got %b %h %h want 1 000001 44ff",
               wr_req, sd_addr, sd_data); n_err++;
    end
    ack_after(0, cnt);
    dl = 1'b0;
    step();
  endtask

  task automatic test_other_index();
    int base;
    base = wa.size();
    index = 16'h0001;
    dl = 1'b1;
    step();
    send(27'd0, 8'h01);
    send(27'd1, 8'h02);
    step();
    n_cmp++;
    if ({wr_req, loading} !== 2'b00 || wa.size() !== base) begin
      $display("FAIL other_index: got req=%b loading=%b writes=%0d want 0 0 %0d",
               wr_req, loading, wa.size(), base); n_err++;
    end
    dl = 1'b0;
    index = 16'h0000;
    step();
  endtask

  task automatic test_boundary();
    int cnt;
    dl = 1'b1;
    step();
    send(27'd4, 8'h01);
    send(27'd4, 8'h02);
    send(27'd5, 8'h03);
    n_cmp++;
    if ({sd_addr, sd_data} !== {24'h000002, 16'h0302}) begin
      $display("FAIL even_overwrite: got %h %h want 000002 0302", sd_addr, sd_data); n_err++;
    end
    ack_after(0, cnt);
    send(27'h00FFFFE, 8'hAB);
    send(27'h00FFFFF, 8'hCD);
    n_cmp++;
    if ({wr_req, sd_addr, sd_data} !== {1'b1, 24'h07FFFF, 16'hCDAB}) begin
      $display("FAIL last_word: got %b %h %h want 1 07ffff cdab", wr_req, sd_addr, sd_data); n_err++;
    end
    ack_after(0, cnt);
    send(27'h0100000, 8'h55);
    send(27'h0100001, 8'h66);
    n_cmp++;
    if (wr_req !== 1'b0) begin
      $display("FAIL limit_discard: got req=%b want 0", wr_req); n_err++;
    end
    dl = 1'b0;
    step();
    n_cmp++;
    if (done !== 1'b1) begin
      $display("FAIL idle_fall_done: got %b want 1", done); n_err++;
    end
    dl = 1'b1;
    step();
    n_cmp++;
    if ({done, loading} !== 2'b01) begin
      $display("FAIL rise_clears_done: got done=%b loading=%b want 0/1", done, loading); n_err++;
    end
  endtask

  task automatic test_fall_in_req();
    int base;
    base = wa.size();
    send(27'd6, 8'h77);
    send(27'd7, 8'h88);
    dl = 1'b0;
    step();
    n_cmp++;
    if (wr_req !== 1'b1) begin
      $display("FAIL fall_req_held: got %b want 1", wr_req); n_err++;
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++;
    if ({done, wr_req, loading} !== 3'b100 || wa.size() !== base + 1) begin
      $display("FAIL fall_req_done: got done=%b req=%b loading=%b writes=%0d want 1 0 0 %0d",
               done, wr_req, loading, wa.size(), base + 1); n_err++;
    end else if ({wa[base], wd[base]} !== {24'h000003, 16'h8877}) begin
      $display("FAIL fall_req_word: got %h %h want 000003 8877", wa[base], wd[base]); n_err++;
    end
  endtask

  task automatic test_reset_mid_req();
    int base;
    dl = 1'b1;
    step();
    send(27'd0, 8'h5A);
    send(27'd1, 8'hA5);
    base = wa.size();
    n_cmp++;
    if (wr_req !== 1'b1) begin
      $display("FAIL rst_setup_req: got %b want 1", wr_req); n_err++;
    end
    rst = 1'b1;
    wr  = 1'b1;
    addr = 27'd2;
    step();
    rst = 1'b0;
    wr  = 1'b0;
    n_cmp++;
    if ({wr_req, wait_o, loading, done, overrun, sd_addr, sd_data} !== '0) begin
      $display("FAIL rst_mid_req: got %b/%b/%b/%b/%b %h %h want all zero",
               wr_req, wait_o, loading, done, overrun, sd_addr, sd_data); n_err++;
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    n_cmp++;
    if (wr_req !== 1'b0 || wa.size() !== base) begin
      $display("FAIL late_ack: got req=%b writes=%0d want 0 %0d", wr_req, wa.size(), base); n_err++;
    end
  endtask

  initial begin
    rst = 1'b1; index = 16'h0000; dl = 1'b0; addr = '0; data = '0; wr = 1'b0; ack = 1'b0;
    test_reset();
    test_basic();
    test_flush();
    test_overrun();
    test_other_index();
    test_boundary();
    test_fall_in_req();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
